// File: rtl/output_display_unit.sv
// ============================================================================
// output_display_unit
// Captures processor OUT results into an 8-entry bank and scans one entry
// onto a multiplexed 8-digit active-low 7-segment display.
// Revision: 1.0
// ============================================================================
`default_nettype none

module output_display_unit #(
  parameter int REFRESH_DIV = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] outval1,
  input  logic [15:0] outval2,
  input  logic [2:0]  outsel,
  input  logic        outdisplay,
  input  logic        halting,
  input  logic [2:0]  view_sel,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        led_halt,
  output logic [7:0]  out_count
);

  localparam int            RW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);

  logic [15:0]   hi_q [8];
  logic [15:0]   lo_q [8];
  logic [7:0]    valid_q;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          led_halt_q;
  logic [7:0]    count_q, count_d;

  logic [15:0]   word_sel;
  logic [3:0]    nibble;
  logic [6:0]    seg7;

  always_comb begin
    rcnt_d = rcnt_q + RW'(1);
    dig_d  = dig_q;
    if (rcnt_q == RCNT_LAST) begin
      rcnt_d = '0;
      dig_d  = dig_q + 3'd1;
    end
  end

  // Digits 7..4 scan the hi word, 3..0 the lo word; dig[1:0] picks the nibble.
  always_comb begin
    word_sel = dig_q[2] ? hi_q[view_sel] : lo_q[view_sel];
    nibble   = word_sel[{dig_q[1:0], 2'b00} +: 4];
    case (nibble)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
    if (!valid_q[view_sel]) begin
      seg7 = 7'b0111111;
    end
    seg_d   = {(dig_q != 3'd4), seg7};
    an_d    = ~(8'b1 << dig_q);
    count_d = (outdisplay && (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        hi_q[i] <= 16'h0000;
        lo_q[i] <= 16'h0000;
      end
      valid_q    <= 8'h00;
      rcnt_q     <= '0;
      dig_q      <= 3'd0;
      seg_q      <= 8'hFF;
      an_q       <= 8'hFF;
      led_halt_q <= 1'b0;
      count_q    <= 8'h00;
    end else begin
      if (outdisplay) begin
        hi_q[outsel]    <= outval1;
        lo_q[outsel]    <= outval2;
        valid_q[outsel] <= 1'b1;
      end
      rcnt_q     <= rcnt_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      led_halt_q <= halting;
      count_q    <= count_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign led_halt  = led_halt_q;
  assign out_count = count_q;

endmodule

`default_nettype wire
